// File: rtl/sync_fifo_pkg.sv
// Shared types, parameter-legality rules and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int MIN_DEPTH      = 4;
    localparam int MIN_DATA_WIDTH = 1;

    // Pointer width: one address bit per power of two plus a wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit width_legal(input int width);
        return width >= MIN_DATA_WIDTH;
    endfunction

    function automatic bit fwft_legal(input int fwft);
        return (fwft == 0) || (fwft == 1);
    endfunction

    function automatic bit af_legal(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_legal(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Output register of the FIFO: registered read (standard) or head-word prefetch (FWFT).
module fifo_out_stage
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pop,
    input  logic                  push,
    input  logic                  mem_empty,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  advance
);

    localparam fifo_mode_e MODE = mode_of(FWFT);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    // Decide what the output register holds next and whether the read pointer moves.
    // In FWFT mode an empty memory with a write in flight bypasses straight to the
    // output so the first word is visible one cycle after it is written.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        advance = 1'b0;
        if (MODE == FIFO_FWFT) begin
            if (!valid_q || pop) begin
                if (!mem_empty) begin
                    data_d  = mem_data;
                    valid_d = 1'b1;
                    advance = 1'b1;
                end else if (push) begin
                    data_d  = push_data;
                    valid_d = 1'b1;
                    advance = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end else begin
            valid_d = pop;
            advance = pop;
            if (pop) begin
                data_d = mem_data;
            end
        end
    end

    // Output register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign r_data  = data_q;
    assign r_valid = valid_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky
// error flags. Optional peak-occupancy watermark under SYNC_FIFO_WATERMARK_EN.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic                    w_full,
    output logic                    w_almost_full,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid,
    output logic                    r_empty,
    output logic                    r_almost_empty,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] peak_count
`endif
);

    localparam int         PW   = ptr_w(DEPTH);
    localparam int         AW   = PW - 1;
    localparam fifo_mode_e MODE = mode_of(FWFT);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two >= %0d", MIN_DEPTH);
    end
    if (!width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("sync_fifo_ctrl: DATA_WIDTH must be >= %0d", MIN_DATA_WIDTH);
    end
    if (!fwft_legal(FWFT)) begin : g_bad_fwft
        $error("sync_fifo_ctrl: FWFT must be 0 or 1");
    end
    if (!af_legal(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_THRESH must lie in 1..DEPTH");
    end
    if (!ae_legal(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]         rd_ptr_d, rd_ptr_q;
    logic [PW-1:0]         count_d, count_q;
    logic                  overflow_d, overflow_q;
    logic                  underflow_d, underflow_q;
    logic                  wr_acc, rd_acc, rd_advance, mem_empty, stage_valid;
    logic [DATA_WIDTH-1:0] mem_data;

    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    assign mem_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Status flags come only from registered state, so r_en never reaches write acceptance.
    always_comb begin
        w_full         = (count_q == PW'(DEPTH));
        w_almost_full  = (int'(count_q) >= AF_THRESH);
        r_almost_empty = (int'(count_q) <= AE_THRESH);
        r_empty        = (MODE == FIFO_FWFT) ? !stage_valid : (count_q == '0);
    end

    // Request acceptance, pointer/count bookkeeping and sticky error flags.
    always_comb begin
        wr_acc      = w_en && !w_full;
        rd_acc      = r_en && !r_empty;
        wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_advance ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + PW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - PW'(1);
        end
        overflow_d  = overflow_q  || (w_en && w_full);
        underflow_d = underflow_q || (r_en && r_empty);
    end

    // Control registers; requests presented during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= w_data;
        end
    end

    fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .FWFT       (FWFT)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .pop       (rd_acc),
        .push      (wr_acc),
        .mem_empty (mem_empty),
        .mem_data  (mem_data),
        .push_data (w_data),
        .r_data    (r_data),
        .r_valid   (stage_valid),
        .advance   (rd_advance)
    );

    assign r_valid   = stage_valid;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [PW-1:0] peak_d, peak_q;

    // Track the highest occupancy seen since reset, one cycle behind count.
    always_comb begin
        peak_d = (count_q > peak_q) ? count_q : peak_q;
    end

    // Watermark register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO and successor to the dual-clock FIFO. It is used wherever producer and consumer share one clock, so no CDC is needed.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Selectable read mode: registered standard read, or first-word-fall-through (FWFT).

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 16, capacity in words; power of two, >=4
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
AF_THRESH, DEPTH-2, w_almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, r_almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  single clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
w_en  in  1  write request
w_data  in  DATA_WIDTH  write payload
w_full  out  1  count == DEPTH
w_almost_full  out  1  count >= AF_THRESH
r_en  in  1  read request (FWFT: pop/acknowledge)
r_data  out  DATA_WIDTH  read payload
r_valid  out  1  r_data holds popped/head word
r_empty  out  1  no word readable
r_almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  words currently stored
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers: binary, width $clog2(DEPTH)+1. Address is taken from the LSBs; the MSB is the wrap bit. Both pointers wrap naturally modulo 2*DEPTH.
- Accepted write: w_en && !w_full. Accepted read: r_en && !r_empty. Both are decided on registered flags only, so there is no combinational path from r_en to write acceptance.
- Simultaneous accepted read and write: count unchanged, both pointers advance. When full, a write with a simultaneous read is rejected. When empty, the read is rejected.
- count: +1 on write only, -1 on read only. Never exceeds DEPTH and never goes below 0.
- Flags are derived from registered state:
  - w_full, w_almost_full and r_almost_empty are combinational from the count register.
- Standard mode (FWFT=0):
  - r_empty = (count==0).
  - An accepted read registers mem[rd_ptr] into r_data, and r_valid pulses high on the next cycle (latency 1).
  - r_data holds its value when there is no read.
- FWFT mode (FWFT=1):
  - The output stage prefetches the head word. r_empty = !out_valid and r_valid = out_valid.
  - A write into an empty FIFO makes r_empty fall exactly 1 cycle after the write is accepted.
  - When r_en is accepted, the next word, if present, is loaded in the same edge with no bubble. Otherwise out_valid clears.
  - count includes the word held in the output stage; capacity remains DEPTH.
- overflow: set on w_en && w_full. underflow: set on r_en && r_empty. Both are cleared only by rst. Rejected requests do not change any other state.
- Reset (including mid-operation):
  - Pointers = 0, count = 0, r_empty = 1, r_almost_empty = 1.
  - w_full = 0, w_almost_full = 0 (AF_THRESH >= 1).
  - r_valid = 0, r_data = 0, overflow = 0, underflow = 0.
  - Storage contents are not cleared. Requests in the reset cycle are ignored.

Optional Feature:
Macro SYNC_FIFO_WATERMARK_EN.
- Defined: adds output port peak_count (width $clog2(DEPTH)+1).
  - peak_count is a register holding the maximum count seen since reset, updated 1 cycle after count changes.
  - Reset value is 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - function ptr_w(depth) returning $clog2(depth)+1
  - the localparam rules for legal parameter ranges, checked by elaboration-time assertions
- One natural sub-module: fifo_out_stage. It holds the output register, r_valid and FWFT prefetch logic, and is parametrised by DATA_WIDTH and FWFT.

Test Plan:
1. DEPTH=16, standard mode: write 0x00..0x0F, then 1 more write -> w_full=1 after the 16th write, w_almost_full=1 from count 14, 17th write rejected, overflow=1, count=16.
2. Drain the full FIFO with r_en held -> r_data = 0x00..0x0F, each with r_valid 1 cycle after its read; r_empty=1 after the 16th read; one extra read sets underflow=1 and count=0.
3. count=8, w_en and r_en together for 40 cycles with incrementing data -> count stays 8, pointers wrap at least twice, output order exactly preserved.
4. FWFT=1, write 0xA5 into an empty FIFO -> r_empty falls 1 cycle later with r_data=0xA5; pop with 0x3C already queued -> r_data=0x3C on the next cycle, no bubble.
5. rst asserted at count=11 with overflow=1 -> next cycle count=0, r_empty=1, overflow=0, r_valid=0; a write in the reset cycle is ignored.
6. SYNC_FIFO_WATERMARK_EN defined: fill to 13, drain to 2 -> peak_count=13; after rst, peak_count=0.
